// File: rtl/alarm_controller_pkg.sv
// Alarm controller shared definitions: FSM state encoding and time-field widths.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package alarm_controller_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

    // Encoding is visible on the state output (debug/LED), so it is fixed.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    function automatic logic time_match(
        input logic [HR_W-1:0]  hr_a,
        input logic [MIN_W-1:0] min_a,
        input logic [HR_W-1:0]  hr_b,
        input logic [MIN_W-1:0] min_b
    );
        return (hr_a == hr_b) && (min_a == min_b);
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Alarm controller signal bundle: time/alarm values, buttons, tick in; ringing, buzzer, state out.
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are levels or one-clk pulses, outputs are levels.
// Ports (slave view): sec_tick, cur_hr, cur_min, alarm_hr, alarm_min, arm, stop, snooze in;
//                     ringing, buzzer, state out.
interface alarm_controller_if;
    import alarm_controller_pkg::*;

    logic             sec_tick;
    logic [HR_W-1:0]  cur_hr;
    logic [MIN_W-1:0] cur_min;
    logic [HR_W-1:0]  alarm_hr;
    logic [MIN_W-1:0] alarm_min;
    logic             arm;
    logic             stop;
    logic             snooze;
    logic             ringing;
    logic             buzzer;
    logic [1:0]       state;

    // master: the time-keeping chain / buttons side that drives the controller
    modport master (
        output sec_tick, cur_hr, cur_min, alarm_hr, alarm_min, arm, stop, snooze,
        input  ringing, buzzer, state
    );

    // slave: the alarm controller itself
    modport slave (
        input  sec_tick, cur_hr, cur_min, alarm_hr, alarm_min, arm, stop, snooze,
        output ringing, buzzer, state
    );

endinterface

// File: rtl/alarm_tone_gen.sv
// Buzzer square-wave generator: toggles buzzer every TONE_DIV clk cycles while enabled.
// Latency: first toggle TONE_DIV clk after en rises; en low clears counter and buzzer on the next edge.
// Backpressure: none.
// Ports: clk, reset (async, active-high), en in; buzzer out (registered).
module alarm_tone_gen #(
    parameter int TONE_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic buzzer
);

    localparam int            TW        = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    logic [TW-1:0] tone_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (!en) begin
            // Silence immediately so the pin never idles high.
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            buzzer   <= ~buzzer;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: detects alarm time, rings for RING_SECS seconds, handles stop (and snooze).
// Latency: ringing/state RINGING 2 clk after cur_min reaches the alarm minute; button/arm effects 1 clk.
// Backpressure: none; inputs are sampled every clk, outputs are registered levels.
// Ports: clk, reset (async, active-high), bus (alarm_controller_if.slave).
// Optional feature: define ALARM_SNOOZE_EN to enable the snooze button and the SNOOZE state.
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int TONE_DIV    = 50000,
    parameter int CW          = 9
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);

    localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
`else
    // Snooze support is compiled out; these only absorb the unused inputs.
    localparam int unused_snooze_secs = SNOOZE_SECS;
    logic          unused_snooze;
    assign unused_snooze = bus.snooze;
`endif

    state_t        state_q, state_d;
    logic          match_r, match_q, trigger;
    logic [CW-1:0] sec_cnt_q, sec_cnt_d;
    logic          ringing_q, ringing_d;
    logic          tone_en;
    logic          buzzer_w;

    // match is registered once, then edge-detected against its own delayed copy.
    // Only the rising edge fires, so a stopped alarm stays quiet for the rest
    // of the minute while re-setting the alarm onto "now" still fires.
    assign trigger = match_r & ~match_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arm=0 wins over everything, then stop, snooze, timeout.
    always_comb begin
        state_d = state_q;
        if (!bus.arm) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                // A trigger coinciding with the arm edge is dropped here.
                S_IDLE:    state_d = S_ARMED;
                S_ARMED:   if (trigger) state_d = S_RINGING;
                S_RINGING: begin
                    if (bus.stop) begin
                        state_d = S_ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.snooze) begin
                        state_d = S_SNOOZE;
`endif
                    end else if (bus.sec_tick && (sec_cnt_q == RING_LAST)) begin
                        state_d = S_ARMED;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (bus.stop) begin
                        state_d = S_ARMED;
                    end else if (bus.sec_tick && (sec_cnt_q == SNOOZE_LAST)) begin
                        state_d = S_RINGING;
                    end
                end
`endif
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        // Every state change restarts the seconds count, so the counter never
        // advances past its terminal value: the terminal tick always leaves the state.
        if (state_d != state_q) begin
            sec_cnt_d = '0;
        end else if (bus.sec_tick && ((state_q == S_RINGING) || (state_q == S_SNOOZE))) begin
            sec_cnt_d = sec_cnt_q + CW'(1);
        end
        ringing_d = (state_d == S_RINGING);
        // Tone runs only while staying in RINGING; leaving clears it on the same edge.
        tone_en   = (state_q == S_RINGING) && (state_d == S_RINGING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_r   <= 1'b0;
            match_q   <= 1'b0;
            sec_cnt_q <= '0;
            ringing_q <= 1'b0;
        end else begin
            match_r   <= time_match(bus.cur_hr, bus.cur_min, bus.alarm_hr, bus.alarm_min);
            match_q   <= match_r;
            sec_cnt_q <= sec_cnt_d;
            ringing_q <= ringing_d;
        end
    end

    alarm_tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk    (clk),
        .reset  (reset),
        .en     (tone_en),
        .buzzer (buzzer_w)
    );

    assign bus.state   = state_q;
    assign bus.ringing = ringing_q;
    assign bus.buzzer  = buzzer_w;

endmodule
